// File: rtl/mult_pkg.sv
// Shared widths, stage indices and the partial-product row helper for the
// pipelined 4x4 multiplier.
package mult_pkg;
  localparam int OP_W     = 4;
  localparam int PROD_W   = 8;
  localparam int N_STAGES = 4;

  localparam int STG0 = 0;
  localparam int STG1 = 1;
  localparam int STG2 = 2;
  localparam int STG3 = 3;

  function automatic logic [OP_W-1:0] pp_row(input logic [OP_W-1:0] a_i,
                                             input logic            bit_i);
    return a_i & {OP_W{bit_i}};
  endfunction
endpackage

// File: rtl/mult_row_stage.sv
// One multiplier pipeline stage: adds partial-product row ROW into the running
// sum with a single rca_4b and registers valid, operands and partial product.
module mult_row_stage
  import mult_pkg::*;
#(
  parameter int ROW = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv_i,
  input  logic              v_i,
  input  logic [OP_W-1:0]   a_i,
  input  logic [OP_W-1:0]   b_i,
  input  logic [PROD_W-1:0] p_i,
  output logic              v_o,
  output logic [OP_W-1:0]   a_o,
  output logic [OP_W-1:0]   b_o,
  output logic [PROD_W-1:0] p_o
);
  logic              v_q, v_d;
  logic [OP_W-1:0]   a_q, a_d, b_q, b_d;
  logic [PROD_W-1:0] p_q, p_d, p_sum;
  logic [OP_W-1:0]   row, sum;
  logic              cout;

  assign row = pp_row(a_i, b_i[ROW]);

  rca_4b u_rca (
    .a    (p_i[ROW+OP_W-1:ROW]),
    .b    (row),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // Bits below ROW are already final; bits above ROW+OP_W are still zero.
  always_comb begin
    p_sum                 = p_i;
    p_sum[ROW+OP_W:ROW]   = {cout, sum};
  end

  always_comb begin
    v_d = v_q;
    a_d = a_q;
    b_d = b_q;
    p_d = p_q;
    if (adv_i) begin
      v_d = v_i;
      a_d = a_i;
      b_d = b_i;
      p_d = p_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
    end else begin
      v_q <= v_d;
      a_q <= a_d;
      b_q <= b_d;
      p_q <= p_d;
    end
  end

  assign v_o = v_q;
  assign a_o = a_q;
  assign b_o = b_q;
  assign p_o = p_q;
endmodule

// File: rtl/rca_1b.sv
// One-bit full adder cell.
module rca_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/rca_4b.sv
// Four-bit ripple-carry adder built from rca_1b cells.
module rca_4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] c;

  assign c[0] = cin;
  assign cout = c[4];

  for (genvar i = 0; i < 4; i++) begin : g_bit
    rca_1b u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .sum  (sum[i]),
      .cout (c[i+1])
    );
  end
endmodule

// File: rtl/pipe_mult_4x4.sv
// Four-stage pipelined 4x4 unsigned multiplier with valid/ready on both sides
// and per-stage bubble collapsing; S0 is inline, S1..S3 are mult_row_stage.
module pipe_mult_4x4
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [PROD_W-1:0] prod,
  output logic              out_valid,
  input  logic              out_ready
);
  logic              v0_q, v0_d, v1, v2, v3;
  logic [OP_W-1:0]   a0_q, a0_d, b0_q, b0_d, a1, b1, a2, b2, a3, b3;
  logic [PROD_W-1:0] p0_q, p0_d, p1, p2, p3;
  logic              adv0, adv1, adv2, adv3;
  logic              unused_s3;

  // A stage may load whenever it is empty or the stage after it moves.
  assign adv3     = !v3   || out_ready;
  assign adv2     = !v2   || adv3;
  assign adv1     = !v1   || adv2;
  assign adv0     = !v0_q || adv1;
  assign in_ready = adv0;

  // S0: operands are captured only on an actual input transfer.
  always_comb begin
    v0_d = v0_q;
    a0_d = a0_q;
    b0_d = b0_q;
    p0_d = p0_q;
    if (adv0) begin
      v0_d = in_valid;
      if (in_valid) begin
        a0_d = a;
        b0_d = b;
        p0_d = {{(PROD_W-OP_W){1'b0}}, pp_row(a, b[0])};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q <= 1'b0;
      a0_q <= '0;
      b0_q <= '0;
      p0_q <= '0;
    end else begin
      v0_q <= v0_d;
      a0_q <= a0_d;
      b0_q <= b0_d;
      p0_q <= p0_d;
    end
  end

  mult_row_stage #(.ROW(STG1)) u_s1 (
    .clk (clk), .rst_n (rst_n), .adv_i (adv1),
    .v_i (v0_q), .a_i (a0_q), .b_i (b0_q), .p_i (p0_q),
    .v_o (v1),   .a_o (a1),   .b_o (b1),   .p_o (p1)
  );

  mult_row_stage #(.ROW(STG2)) u_s2 (
    .clk (clk), .rst_n (rst_n), .adv_i (adv2),
    .v_i (v1), .a_i (a1), .b_i (b1), .p_i (p1),
    .v_o (v2), .a_o (a2), .b_o (b2), .p_o (p2)
  );

  mult_row_stage #(.ROW(STG3)) u_s3 (
    .clk (clk), .rst_n (rst_n), .adv_i (adv3),
    .v_i (v2), .a_i (a2), .b_i (b2), .p_i (p2),
    .v_o (v3), .a_o (a3), .b_o (b3), .p_o (p3)
  );

  // The last stage's operand copies have no consumer.
  assign unused_s3 = ^{a3, b3};

  assign prod      = p3;
  assign out_valid = v3;
endmodule
